// File: rtl/mem_io_responder.sv
// Memory/IO responder for the CPU byte bus: byte RAM with one-cycle read
// latency plus memory-mapped UART tx FIFO, rx hold register, cycle counter
// and program-stop control at 0x30000-0x30007.
module mem_io_responder #(
   parameter int unsigned ADDR_BITS       = 17,
   parameter int unsigned TX_FIFO_DEPTH   = 8,
   parameter int unsigned TX_DRAIN_CYCLES = 4
) (
   input  logic        clk_in,
   input  logic        rst_in,
   input  logic [31:0] mem_a,
   input  logic        mem_wr,
   input  logic [7:0]  mem_dout,
   output logic [7:0]  mem_din,
   output logic        io_buffer_full,
   input  logic        rx_valid,
   input  logic [7:0]  rx_data,
   output logic        rx_ready,
   output logic        tx_valid,
   output logic [7:0]  tx_data,
   input  logic        tx_ready,
   output logic        tx_overflow,
   output logic        halt
);

   localparam int unsigned IDX_W  = $clog2(TX_FIFO_DEPTH);
   localparam int unsigned PTR_W  = IDX_W + 1;
   localparam int unsigned PACE_W = $clog2(TX_DRAIN_CYCLES + 1);

   localparam logic [PTR_W-1:0]  DEPTH_CNT = PTR_W'(TX_FIFO_DEPTH);
   localparam logic [PTR_W-1:0]  NEAR_FULL = PTR_W'(TX_FIFO_DEPTH - 1);
   localparam logic [PACE_W-1:0] PACE_LOAD = PACE_W'(TX_DRAIN_CYCLES - 1);

   localparam logic [15:0] OFF_UART = 16'h0000;
   localparam logic [15:0] OFF_CNT0 = 16'h0004;
   localparam logic [15:0] OFF_CNT1 = 16'h0005;
   localparam logic [15:0] OFF_CNT2 = 16'h0006;
   localparam logic [15:0] OFF_CNT3 = 16'h0007;

   logic [7:0]        ram [2**ADDR_BITS];
   logic [7:0]        fifo [TX_FIFO_DEPTH];

   logic [PTR_W-1:0]  wr_ptr;
   logic [PTR_W-1:0]  rd_ptr;
   logic [PTR_W-1:0]  count;
   logic [PACE_W-1:0] pace;
   logic              ovf_q;

   logic              hold_valid;
   logic [7:0]        rx_hold;

   logic [31:0]       counter;
   // Byte 0 is served live from the counter, so only bytes 1..3 are kept.
   logic [31:8]       snapshot;

   logic              stop_req;
   logic              halt_q;

   logic              io;
   logic [15:0]       io_off;
   logic              ram_wr;
   logic              push_req;
   logic              stop_wr;
   logic              rx_rd;
   logic              cnt_rd;
   logic              fifo_full;
   logic              pop;
   logic              push_ok;
   logic              ovf_set;

   // Address bits above the decoded range are deliberately ignored.
   logic              unused_addr_bits;
   assign unused_addr_bits = ^mem_a[31:18];

   // Bus decode; every access strobe is suppressed while reset is held.
   always_comb begin
      io       = (mem_a[17:16] == 2'b11);
      io_off   = mem_a[15:0];
      ram_wr   = 1'b0;
      push_req = 1'b0;
      stop_wr  = 1'b0;
      rx_rd    = 1'b0;
      cnt_rd   = 1'b0;
      if (!rst_in) begin
         ram_wr   = !io && mem_wr;
         push_req = io && mem_wr && (io_off == OFF_UART) && (mem_dout != 8'h00);
         stop_wr  = io && mem_wr && (io_off == OFF_CNT0);
         rx_rd    = io && !mem_wr && (io_off == OFF_UART);
         cnt_rd   = io && !mem_wr && (io_off == OFF_CNT0);
      end
   end

   // FIFO status and handshake; a pop in the same cycle frees room for a push.
   always_comb begin
      count          = wr_ptr - rd_ptr;
      fifo_full      = (count == DEPTH_CNT);
      io_buffer_full = (count >= NEAR_FULL);
      tx_valid       = (count != '0) && (pace == '0);
      tx_data        = fifo[rd_ptr[IDX_W-1:0]];
      pop            = tx_valid && tx_ready && !rst_in;
      push_ok        = push_req && (!fifo_full || pop);
      ovf_set        = push_req && fifo_full && !pop;
      rx_ready       = !hold_valid;
      tx_overflow    = ovf_q;
      halt           = halt_q || (stop_req && (count == '0));
   end

   // RAM write port; contents survive reset.
   always_ff @(posedge clk_in) begin
      if (ram_wr) begin
         ram[mem_a[ADDR_BITS-1:0]] <= mem_dout;
      end
   end

   // FIFO storage write port.
   always_ff @(posedge clk_in) begin
      if (push_ok) begin
         fifo[wr_ptr[IDX_W-1:0]] <= mem_dout;
      end
   end

   // FIFO pointers, drain pacing and sticky overflow flag.
   always_ff @(posedge clk_in) begin
      if (rst_in) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         pace   <= '0;
         ovf_q  <= 1'b0;
      end else begin
         if (push_ok) begin
            wr_ptr <= wr_ptr + PTR_W'(1);
         end
         if (pop) begin
            rd_ptr <= rd_ptr + PTR_W'(1);
            pace   <= PACE_LOAD;
         end else if (pace != '0) begin
            pace <= pace - PACE_W'(1);
         end
         if (ovf_set) begin
            ovf_q <= 1'b1;
         end
      end
   end

   // rx hold register: a read clears it; capture only while it is empty.
   always_ff @(posedge clk_in) begin
      if (rst_in) begin
         hold_valid <= 1'b0;
         rx_hold    <= '0;
      end else if (rx_rd && hold_valid) begin
         hold_valid <= 1'b0;
      end else if (rx_valid && rx_ready) begin
         hold_valid <= 1'b1;
         rx_hold    <= rx_data;
      end
   end

   // Free-running cycle counter and snapshot taken on a byte-0 read.
   always_ff @(posedge clk_in) begin
      if (rst_in) begin
         counter  <= '0;
         snapshot <= '0;
      end else begin
         counter <= counter + 32'd1;
         if (cnt_rd) begin
            snapshot <= counter[31:8];
         end
      end
   end

   // Stop request and sticky halt once the tx FIFO has drained.
   always_ff @(posedge clk_in) begin
      if (rst_in) begin
         stop_req <= 1'b0;
         halt_q   <= 1'b0;
      end else begin
         if (stop_wr) begin
            stop_req <= 1'b1;
         end
         halt_q <= halt;
      end
   end

   // Registered read data: RAM or IO register, zero on writes and in reset.
   always_ff @(posedge clk_in) begin
      if (rst_in || mem_wr) begin
         mem_din <= '0;
      end else if (!io) begin
         mem_din <= ram[mem_a[ADDR_BITS-1:0]];
      end else begin
         case (io_off)
            OFF_UART: mem_din <= hold_valid ? rx_hold : 8'h00;
            OFF_CNT0: mem_din <= counter[7:0];
            OFF_CNT1: mem_din <= snapshot[15:8];
            OFF_CNT2: mem_din <= snapshot[23:16];
            OFF_CNT3: mem_din <= snapshot[31:24];
            default:  mem_din <= '0;
         endcase
      end
   end

endmodule

// File: tb/tb_mem_io_responder.sv
// Scoreboard bench for mem_io_responder: the stimulus pushes expected read
// data and expected tx bytes into queues; monitors pop and compare them.
module tb_mem_io_responder;

   localparam logic [31:0] A_UART = 32'h0003_0000;
   localparam logic [31:0] A_CNT0 = 32'h0003_0004;
   localparam logic [31:0] A_IDLE = 32'h0003_0010;

   logic        clk_in = 1'b0;
   logic        rst_in = 1'b1;
   logic [31:0] mem_a = A_IDLE;
   logic        mem_wr = 1'b0;
   logic [7:0]  mem_dout = '0;
   logic [7:0]  mem_din;
   logic        io_buffer_full;
   logic        rx_valid = 1'b0;
   logic [7:0]  rx_data = '0;
   logic        rx_ready;
   logic        tx_valid;
   logic [7:0]  tx_data;
   logic        tx_ready = 1'b0;
   logic        tx_overflow;
   logic        halt;

   // Values applied together with the next bus cycle.
   logic        rst_q = 1'b1;
   logic        rxv_q = 1'b0;
   logic [7:0]  rxd_q = '0;
   logic        txr_q = 1'b0;

   typedef struct {
      int          tag;
      logic [31:0] addr;
      logic [7:0]  exp;
   } rd_exp_t;

   rd_exp_t     rd_q[$];
   logic [7:0]  tx_q[$];

   int          vectors = 0;
   int          miscompares = 0;
   int          cyc_n = 0;
   int          tx_pops = 0;
   int          last_pop = -1;
   int          base;

   mem_io_responder #(
      .ADDR_BITS(17),
      .TX_FIFO_DEPTH(8),
      .TX_DRAIN_CYCLES(4)
   ) dut (
      .clk_in(clk_in),
      .rst_in(rst_in),
      .mem_a(mem_a),
      .mem_wr(mem_wr),
      .mem_dout(mem_dout),
      .mem_din(mem_din),
      .io_buffer_full(io_buffer_full),
      .rx_valid(rx_valid),
      .rx_data(rx_data),
      .rx_ready(rx_ready),
      .tx_valid(tx_valid),
      .tx_data(tx_data),
      .tx_ready(tx_ready),
      .tx_overflow(tx_overflow),
      .halt(halt)
   );

   always #5 clk_in = ~clk_in;

   initial forever begin
      @(posedge clk_in);
      cyc_n++;
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc_n);
      end
   endtask

   // One bus cycle: drive just after the edge, sampled at the following edge.
   task automatic bus(input logic [31:0] a, input logic wr, input logic [7:0] d,
                      input logic [7:0] exp);
      rd_exp_t e;
      @(posedge clk_in);
      #1;
      rst_in   = rst_q;
      rx_valid = rxv_q;
      rx_data  = rxd_q;
      tx_ready = txr_q;
      mem_a    = a;
      mem_wr   = wr;
      mem_dout = d;
      e.tag  = cyc_n;
      e.addr = a;
      e.exp  = exp;
      rd_q.push_back(e);
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) begin
         bus(A_IDLE, 1'b0, 8'h00, 8'h00);
      end
   endtask

   // Read-data monitor: each issued access is answered one edge later.
   initial begin
      rd_exp_t e;
      forever begin
         @(negedge clk_in);
         if (rd_q.size() > 0 && rd_q[0].tag < cyc_n) begin
            e = rd_q.pop_front();
            check($sformatf("mem_din@%05h", e.addr[19:0]), {24'h0, mem_din}, {24'h0, e.exp});
         end
      end
   end

   // tx monitor: every handshake must match the next expected byte and pacing.
   initial begin
      forever begin
         @(negedge clk_in);
         if (tx_valid === 1'b1 && tx_ready === 1'b1) begin
            if (tx_q.size() == 0) begin
               vectors++;
               miscompares++;
               $display("FAIL tx_pop: got unexpected byte %02h, expected no pop (cycle %0d)",
                        tx_data, cyc_n);
            end else begin
               check("tx_data", {24'h0, tx_data}, {24'h0, tx_q.pop_front()});
            end
            if (last_pop >= 0) begin
               check("tx_gap_ge_4", {31'h0, (cyc_n - last_pop) >= 4}, 32'd1);
            end
            last_pop = cyc_n;
            tx_pops++;
         end
      end
   end

   initial begin
      // Reset, then 1000 idle cycles before sampling the cycle counter.
      rst_q = 1'b1;
      idle(3);
      rst_q = 1'b0;
      idle(1);
      check("rst_tx_valid", {31'h0, tx_valid}, 32'd0);
      check("rst_tx_overflow", {31'h0, tx_overflow}, 32'd0);
      check("rst_halt", {31'h0, halt}, 32'd0);
      check("rst_io_buffer_full", {31'h0, io_buffer_full}, 32'd0);
      check("rst_rx_ready", {31'h0, rx_ready}, 32'd1);
      idle(999);
      bus(A_CNT0,         1'b0, 8'h00, 8'hE8);
      bus(A_CNT0 + 32'd1, 1'b0, 8'h00, 8'h03);
      bus(A_CNT0 + 32'd2, 1'b0, 8'h00, 8'h00);
      bus(A_CNT0 + 32'd3, 1'b0, 8'h00, 8'h00);

      // RAM write then read-back, and pipelined reads.
      bus(32'h0_0010, 1'b1, 8'hA5, 8'h00);
      bus(32'h0_0010, 1'b0, 8'h00, 8'hA5);
      bus(32'h0_0000, 1'b1, 8'h11, 8'h00);
      bus(32'h0_0001, 1'b1, 8'h22, 8'h00);
      bus(32'h0_0000, 1'b0, 8'h00, 8'h11);
      bus(32'h0_0001, 1'b0, 8'h00, 8'h22);
      bus(32'h0_0010, 1'b0, 8'h00, 8'hA5);

      // 'H', 0x00, 'i' with tx_ready high: the zero byte is dropped.
      txr_q = 1'b1;
      tx_q.push_back(8'h48);
      bus(A_UART, 1'b1, 8'h48, 8'h00);
      bus(A_UART, 1'b1, 8'h00, 8'h00);
      tx_q.push_back(8'h69);
      bus(A_UART, 1'b1, 8'h69, 8'h00);
      idle(8);

      // Fill with tx_ready low: near-full at 7, 8th accepted, 9th dropped.
      txr_q = 1'b0;
      for (int i = 1; i <= 9; i++) begin
         if (i <= 8) tx_q.push_back(8'(i));
         bus(A_UART, 1'b1, 8'(i), 8'h00);
         check($sformatf("io_buffer_full_cnt%0d", i - 1), {31'h0, io_buffer_full},
               {31'h0, (i - 1) >= 7});
         check("tx_overflow_pre", {31'h0, tx_overflow}, 32'd0);
      end
      // Push into a full FIFO while a pop happens: accepted.
      txr_q = 1'b1;
      tx_q.push_back(8'h0A);
      bus(A_UART, 1'b1, 8'h0A, 8'h00);
      check("tx_overflow_set", {31'h0, tx_overflow}, 32'd1);
      check("io_buffer_full_8", {31'h0, io_buffer_full}, 32'd1);
      idle(1);
      check("io_buffer_full_push_pop", {31'h0, io_buffer_full}, 32'd1);
      idle(40);
      check("tx_valid_drained", {31'h0, tx_valid}, 32'd0);
      check("io_buffer_full_drained", {31'h0, io_buffer_full}, 32'd0);
      check("tx_overflow_sticky", {31'h0, tx_overflow}, 32'd1);

      // rx hold: capture, read twice, then read-clear colliding with rx_valid.
      txr_q = 1'b0;
      rxv_q = 1'b1;
      rxd_q = 8'h31;
      idle(1);
      rxv_q = 1'b0;
      idle(1);
      check("rx_ready_held", {31'h0, rx_ready}, 32'd0);
      bus(A_UART, 1'b0, 8'h00, 8'h31);
      check("rx_ready_before_read", {31'h0, rx_ready}, 32'd0);
      bus(A_UART, 1'b0, 8'h00, 8'h00);
      check("rx_ready_after_read", {31'h0, rx_ready}, 32'd1);
      rxv_q = 1'b1;
      rxd_q = 8'h41;
      idle(1);
      rxd_q = 8'h55;
      bus(A_UART, 1'b0, 8'h00, 8'h41);
      check("rx_ready_collide", {31'h0, rx_ready}, 32'd0);
      rxv_q = 1'b0;
      bus(A_UART, 1'b0, 8'h00, 8'h00);
      check("rx_not_captured", {31'h0, rx_ready}, 32'd1);
      idle(1);

      // Stop with 3 bytes queued: halt only after the third pop.
      tx_q.push_back(8'h61);
      tx_q.push_back(8'h62);
      tx_q.push_back(8'h63);
      bus(A_UART, 1'b1, 8'h61, 8'h00);
      bus(A_UART, 1'b1, 8'h62, 8'h00);
      bus(A_UART, 1'b1, 8'h63, 8'h00);
      bus(A_CNT0, 1'b1, 8'h01, 8'h00);
      idle(1);
      check("halt_pending", {31'h0, halt}, 32'd0);
      base  = tx_pops;
      txr_q = 1'b1;
      for (int k = 1; k <= 14; k++) begin
         idle(1);
         check($sformatf("halt_k%0d", k), {31'h0, halt}, {31'h0, (tx_pops - base) == 3});
      end

      // Writes after stop still queue; reset mid-drain clears everything.
      txr_q = 1'b0;
      tx_q.push_back(8'h71);
      bus(A_UART, 1'b1, 8'h71, 8'h00);
      bus(A_UART, 1'b1, 8'h72, 8'h00);
      bus(A_UART, 1'b1, 8'h73, 8'h00);
      idle(1);
      check("halt_sticky", {31'h0, halt}, 32'd1);
      check("tx_valid_queued", {31'h0, tx_valid}, 32'd1);
      txr_q = 1'b1;
      idle(1);
      txr_q = 1'b0;
      rst_q = 1'b1;
      idle(2);
      rst_q = 1'b0;
      idle(1);
      check("mid_rst_halt", {31'h0, halt}, 32'd0);
      check("mid_rst_tx_valid", {31'h0, tx_valid}, 32'd0);
      check("mid_rst_tx_overflow", {31'h0, tx_overflow}, 32'd0);
      check("mid_rst_io_buffer_full", {31'h0, io_buffer_full}, 32'd0);
      check("mid_rst_rx_ready", {31'h0, rx_ready}, 32'd1);
      txr_q = 1'b1;
      for (int k = 0; k < 10; k++) begin
         idle(1);
         check("post_rst_tx_valid", {31'h0, tx_valid}, 32'd0);
         check("post_rst_halt", {31'h0, halt}, 32'd0);
      end

      repeat (3) @(negedge clk_in);
      check("rd_q_empty", rd_q.size(), 32'd0);
      check("tx_q_empty", tx_q.size(), 32'd0);
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule

// File: doc/mem_io_responder.md
Name: mem_io_responder

Overview:
- Memory/IO side of the CPU byte bus: answers `mem_a` / `mem_wr` / `mem_dout` from the core with `mem_din` one cycle later, and drives `io_buffer_full`.
- Holds 2^ADDR_BITS bytes of RAM and models the memory-mapped IO at 0x30000–0x30007: UART tx FIFO with paced drain, single-byte rx hold, cycle-counter read, program-stop.
- Used as the simulation/FPGA-side partner of the core.

Parameters:
- ADDR_BITS, 17, RAM byte-address width (128 KB).
- TX_FIFO_DEPTH, 8, tx FIFO entries; power of two, at least 4.
- TX_DRAIN_CYCLES, 4, minimum cycles between consecutive tx pops (UART pacing); at least 1.

Ports:
- clk_in  in  1  system clock.
- rst_in  in  1  reset; synchronous, active-high.
- mem_a  in  32  byte address from core; only bits 17:0 are decoded.
- mem_wr  in  1  1 = write, 0 = read.
- mem_dout  in  8  write data from core.
- mem_din  out  8  read data to core, registered.
- io_buffer_full  out  1  tx FIFO near-full.
- rx_valid  in  1  host offers an input byte.
- rx_data  in  8  input byte.
- rx_ready  out  1  rx hold register empty (can accept).
- tx_valid  out  1  output byte available to host.
- tx_data  out  8  output byte (FIFO head).
- tx_ready  in  1  host accepts the tx byte.
- tx_overflow  out  1  sticky: a tx write was dropped because the FIFO was full.
- halt  out  1  sticky: program stopped and tx drained.

Behaviour:
- Decode: `io = (mem_a[17:16] == 2'b11)`. Non-IO accesses index RAM with `mem_a[ADDR_BITS-1:0]`. RAM contents are not cleared by reset.
- RAM read (`mem_wr = 0`): `mem_din` updates at the next edge with `ram[addr]` (latency 1). The core issues an address every cycle, so reads are fully pipelined.
- RAM write (`mem_wr = 1`): RAM updates at the edge, single cycle. A read of the same address in the following cycle returns the new data. During a write cycle `mem_din` returns 0.
- IO write 0x30000:
  - Data 0: ignored.
  - Otherwise: push onto the tx FIFO if not full. If full, the byte is dropped and `tx_overflow` is set.
- IO write 0x30004: sets internal `stop_req` (sticky). `halt` rises the first cycle with `stop_req = 1` and FIFO empty, and stays high until reset. Writes arriving after `stop_req` are still processed.
- IO read 0x30000:
  - If the rx hold is valid: `mem_din <= rx_hold` next cycle and the hold is cleared.
  - Otherwise: `mem_din <= 0`.
- rx capture: when `rx_valid && rx_ready`, the hold is loaded. `rx_ready = !hold_valid`, combinational from the register.
  - A read-clear and a new `rx_valid` in the same cycle: the read returns the old byte; the new byte is not captured that cycle because `rx_ready` was low.
- IO read 0x30004–0x30007:
  - 32-bit cycle counter: 0 at reset, +1 every cycle, wraps at 2^32.
  - A read of 0x30004 returns `counter[7:0]` and latches a snapshot of the full counter value.
  - Reads of 0x30005/6/7 return snapshot bytes 1/2/3, giving a consistent 4-byte little-endian value.
- Other IO addresses: reads return 0, writes are ignored.
- tx FIFO:
  - Circular buffer with `log2(DEPTH)+1`-bit wrapping read and write pointers; count = difference of the pointers.
  - `io_buffer_full = (count >= DEPTH-1)`, registered-count based, so one write already in flight still fits.
  - `tx_valid = (count != 0) && (pace == 0)`; `tx_data = fifo[rd_ptr]`.
  - Pop on `tx_valid && tx_ready`: `pace` loads TX_DRAIN_CYCLES-1, then decrements to 0.
  - Simultaneous push and pop: count unchanged; both pointers advance.
  - Push when count == DEPTH and pop in the same cycle: push is accepted, no overflow.
- Reset (`rst_in` high at the edge), also mid-operation:
  - Cleared: FIFO pointers, pace, counter, snapshot, rx hold, `stop_req`.
  - Outputs: `mem_din = 0`, `tx_valid = 0`, `tx_overflow = 0`, `halt = 0`, `io_buffer_full = 0`, `rx_ready = 1`.
  - Any access presented during reset is ignored.

Test Plan:
- Write 0xA5 to 0x00010, then read 0x00010 in the next cycle -> `mem_din` = 0xA5 one cycle after the read; back-to-back reads of 0x0/0x1 pipeline at 1 byte/cycle.
- With `tx_ready = 1`, write 'H', 0x00, 'i' to 0x30000 -> `tx_data` sequence 0x48, 0x69 only, pops separated by ≥4 cycles.
- With `tx_ready = 0`, write 8 nonzero bytes -> `io_buffer_full` high once count = 7; the 8th is accepted; a 9th write sets `tx_overflow`, FIFO still holds bytes 1–8.
- Hold the core idle 1000 cycles after reset, then read 0x30004..0x30007 on consecutive cycles -> assembled value equals the counter at the 0x30004 read (≈1000), not torn.
- `rx_valid` with 0x31, then read 0x30000 twice -> 0x31, then 0x00; `rx_ready` low between capture and the first read.
- Queue 3 tx bytes with `tx_ready = 0`, write 0x30004, then release `tx_ready` -> `halt` asserts only in the cycle after the third pop; asserting `rst_in` mid-drain clears `halt`, `tx_valid`, and FIFO contents.
